cmp_serializer: RTL and testbench

Upstream feeder for the serial magnitude comparator FSM. It accepts parallel operand pairs over a valid/ready handshake and shifts them out LSB-first as continuous, back-to-back WIDTH-bit frames on the comparator's serial A/B inputs. It captures the comparator's one-hot {M,R,W} result for each frame, checks it against an arithmetic compare of the held operands, and reports code, operands and error flag as a single-cycle result pulse. Its frame counter comes out of reset together with the comparator, so the two stay frame-aligned without a start strobe.

---
 rtl/cmp_pkg.sv | 27 ++
 rtl/cmp_serializer_if.sv | 33 +++
 rtl/cmp_piso.sv | 28 ++
 rtl/cmp_serializer.sv | 151 +++++++++++++++
 tb/tb_cmp_serializer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cmp_pkg.sv
// Shared types for the serial magnitude comparator and its serializer.
// The enum encodes the comparator's one-hot {M,R,W} output.
package cmp_pkg;

  typedef enum logic [2:0] {
    OTHER  = 3'b000,
    A_GT_B = 3'b001,
    A_EQ_B = 3'b010,
    A_LS_B = 3'b100
  } output_e;

  typedef enum logic {
    FrBubble,
    FrData
  } frame_e;

  // Operands are zero-extended by callers, so this is an unsigned compare.
  function automatic output_e exp_code(input logic [31:0] a, input logic [31:0] b);
    if (a > b) begin
      return A_GT_B;
    end else if (a < b) begin
      return A_LS_B;
    end
    return A_EQ_B;
  endfunction

endpackage

// File: rtl/cmp_serializer_if.sv
// Operand handshake, serial comparator link and result bus of cmp_serializer.
interface cmp_serializer_if #(
  parameter int unsigned WIDTH = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_bus;
  logic [WIDTH-1:0] b_bus;
  logic             a_o;
  logic             b_o;
  logic             cmp_m;
  logic             cmp_r;
  logic             cmp_w;
  logic             res_valid;
  logic [2:0]       res_code;
  logic [WIDTH-1:0] res_a;
  logic [WIDTH-1:0] res_b;
  logic             res_err;
  logic             err_sticky;

  // Environment side: operand source, comparator and result sink.
  modport master (
    output in_valid, a_bus, b_bus, cmp_m, cmp_r, cmp_w,
    input  in_ready, a_o, b_o, res_valid, res_code, res_a, res_b, res_err, err_sticky
  );

  // Serializer side.
  modport slave (
    input  in_valid, a_bus, b_bus, cmp_m, cmp_r, cmp_w,
    output in_ready, a_o, b_o, res_valid, res_code, res_a, res_b, res_err, err_sticky
  );

endinterface

// File: rtl/cmp_piso.sv
// Parallel-load, LSB-first shift register; the LSB is the serial output.
module cmp_piso #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ser_o
);

  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = load_i ? data_i : {1'b0, sr_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign ser_o = sr_q[0];

endmodule

// File: rtl/cmp_serializer.sv
// Feeds back-to-back WIDTH-bit frames to the serial comparator and checks its
// {M,R,W} result against an arithmetic compare of the operands of each frame.
module cmp_serializer
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  cmp_serializer_if.slave   sif
);

  localparam int unsigned SlotW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [SlotW-1:0] LastSlot = SlotW'(WIDTH - 1);

  logic [SlotW-1:0] slot_q, slot_d;
  frame_e           frame_q, frame_d;
  logic [WIDTH-1:0] tag_a_q, tag_a_d;
  logic [WIDTH-1:0] tag_b_q, tag_b_d;
  logic             pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0] pend_a_q, pend_a_d;
  logic [WIDTH-1:0] pend_b_q, pend_b_d;
  logic             res_valid_q, res_valid_d;
  logic [2:0]       res_code_q, res_code_d;
  logic [WIDTH-1:0] res_a_q, res_a_d;
  logic [WIDTH-1:0] res_b_q, res_b_d;
  logic             res_err_q, res_err_d;
  logic             err_sticky_q, err_sticky_d;

  logic             frame_end;
  logic             xfer;
  logic             capture;
  logic [2:0]       cap_code;
  output_e          want_code;
  logic [WIDTH-1:0] load_a;
  logic [WIDTH-1:0] load_b;

  assign frame_end = (slot_q == LastSlot);
  assign xfer      = sif.in_valid & frame_end;
  // Comparator result for the previous frame is stable during slot 0.
  assign capture   = pend_valid_q & (slot_q == '0);
  assign cap_code  = {sif.cmp_m, sif.cmp_r, sif.cmp_w};
  assign want_code = exp_code(32'(pend_a_q), 32'(pend_b_q));

  // Idle frame ends reload zeros so bubbles shift out as all-zero frames.
  assign load_a = xfer ? sif.a_bus : '0;
  assign load_b = xfer ? sif.b_bus : '0;

  always_comb begin
    slot_d       = frame_end ? '0 : slot_q + SlotW'(1);
    frame_d      = frame_q;
    tag_a_d      = tag_a_q;
    tag_b_d      = tag_b_q;
    pend_valid_d = pend_valid_q;
    pend_a_d     = pend_a_q;
    pend_b_d     = pend_b_q;

    if (frame_end) begin
      frame_d      = xfer ? FrData : FrBubble;
      pend_valid_d = (frame_q == FrData);
      pend_a_d     = tag_a_q;
      pend_b_d     = tag_b_q;
      if (xfer) begin
        tag_a_d = sif.a_bus;
        tag_b_d = sif.b_bus;
      end
    end
  end

  always_comb begin
    res_valid_d  = capture;
    res_code_d   = res_code_q;
    res_a_d      = res_a_q;
    res_b_d      = res_b_q;
    res_err_d    = 1'b0;

    if (capture) begin
      res_code_d = cap_code;
      res_a_d    = pend_a_q;
      res_b_d    = pend_b_q;
      res_err_d  = (cap_code != want_code);
    end

    err_sticky_d = err_sticky_q | res_err_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q       <= '0;
      frame_q      <= FrBubble;
      tag_a_q      <= '0;
      tag_b_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_a_q     <= '0;
      pend_b_q     <= '0;
      res_valid_q  <= 1'b0;
      res_code_q   <= '0;
      res_a_q      <= '0;
      res_b_q      <= '0;
      res_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      frame_q      <= frame_d;
      tag_a_q      <= tag_a_d;
      tag_b_q      <= tag_b_d;
      pend_valid_q <= pend_valid_d;
      pend_a_q     <= pend_a_d;
      pend_b_q     <= pend_b_d;
      res_valid_q  <= res_valid_d;
      res_code_q   <= res_code_d;
      res_a_q      <= res_a_d;
      res_b_q      <= res_b_d;
      res_err_q    <= res_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  cmp_piso #(
    .WIDTH (WIDTH)
  ) u_piso_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (frame_end),
    .data_i (load_a),
    .ser_o  (sif.a_o)
  );

  cmp_piso #(
    .WIDTH (WIDTH)
  ) u_piso_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (frame_end),
    .data_i (load_b),
    .ser_o  (sif.b_o)
  );

  assign sif.in_ready   = frame_end;
  assign sif.res_valid  = res_valid_q;
  assign sif.res_code   = res_code_q;
  assign sif.res_a      = res_a_q;
  assign sif.res_b      = res_b_q;
  assign sif.res_err    = res_err_q;
  assign sif.err_sticky = err_sticky_q;

  // At most one result per frame, so pulses can never be adjacent.
  res_pulse_a : assert property (@(posedge clk) disable iff (!rst_n)
    res_valid_q |=> !res_valid_q);

endmodule

// File: tb/tb_cmp_serializer.sv
// Bench for cmp_serializer: behavioural serial comparator plus result scoreboard.
module tb_cmp_serializer;
  import cmp_pkg::*;

  localparam int unsigned W = 3;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         f;
    logic [2:0]   code;
    logic         err;
  } vec_t;

  typedef struct {
    logic [2:0]   code;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         err;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cmp_serializer_if #(.WIDTH(W)) ifc ();

  cmp_serializer #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (ifc.slave)
  );

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   res_cnt = 0;
  int   last_res = 0;
  bit   have_prev = 0;
  bit   gap_en = 0;
  exp_t sb[$];
  vec_t tbl[9];

  logic       force_req = 1'b0;
  logic [2:0] drv_code = 3'b000;
  logic       drv_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
  endtask

  function automatic logic [2:0] ref_code(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a > b) return 3'b001;
    if (a < b) return 3'b100;
    return 3'b010;
  endfunction

  // Behavioural LSB-first serial comparator; later (more significant) bits win.
  int unsigned m_slot;
  logic        m_gt, m_lt, m_zero;
  logic [2:0]  m_code;
  always @(posedge clk or negedge rst_n) begin : mdl
    logic g, l;
    if (!rst_n) begin
      m_slot <= 0; m_gt <= 1'b0; m_lt <= 1'b0; m_code <= 3'b000; m_zero <= 1'b0;
    end else begin
      g = m_gt;
      l = m_lt;
      if (ifc.a_o && !ifc.b_o) begin g = 1'b1; l = 1'b0; end
      else if (!ifc.a_o && ifc.b_o) begin g = 1'b0; l = 1'b1; end
      if (m_slot == W - 1) begin
        m_slot <= 0; m_gt <= 1'b0; m_lt <= 1'b0;
        m_code <= m_zero ? 3'b000 : (l ? 3'b100 : (g ? 3'b001 : 3'b010));
        m_zero <= force_req && ifc.in_valid && ifc.in_ready;
      end else begin
        m_slot <= m_slot + 1; m_gt <= g; m_lt <= l;
      end
    end
  end

  assign ifc.cmp_m = m_code[2];
  assign ifc.cmp_r = m_code[1];
  assign ifc.cmp_w = m_code[0];

  always @(posedge clk) cyc++;

  // Scoreboard: push on handshake, pop and compare on each result pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.in_valid && ifc.in_ready)
        sb.push_back('{code: drv_code, a: ifc.a_bus, b: ifc.b_bus, err: drv_err, cyc: cyc});
      if (ifc.res_valid) begin
        res_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_res_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("res_code", ifc.res_code, e.code);
          chk("res_a", ifc.res_a, e.a);
          chk("res_b", ifc.res_b, e.b);
          chk("res_err", ifc.res_err, e.err);
          chk("latency", cyc - e.cyc, W + 2);
          if (e.err) chk("err_sticky_set", ifc.err_sticky, 1);
        end
        if (gap_en && have_prev) chk("res_gap", cyc - last_res, W);
        have_prev = 1;
        last_res = cyc;
      end
    end
  end

  // Drive at posedge+1; returns at posedge+1 right after the transfer edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic f,
                      input logic [2:0] code, input logic err);
    bit done;
    ifc.in_valid = 1'b1; ifc.a_bus = a; ifc.b_bus = b;
    force_req = f; drv_code = code; drv_err = err;
    done = 0;
    for (int i = 0; i < 2 * W && !done; i++) begin
      @(negedge clk);
      if (ifc.in_ready) done = 1;
    end
    if (!done) chk("handshake_timeout", 1, 0);
    @(posedge clk); #1;
    ifc.in_valid = 1'b0; force_req = 1'b0;
  endtask

  task automatic send_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    send(a, b, 1'b0, ref_code(a, b), 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_a_o"}, ifc.a_o, 0);
    chk({tag, "_b_o"}, ifc.b_o, 0);
    chk({tag, "_in_ready"}, ifc.in_ready, 0);
    chk({tag, "_res_valid"}, ifc.res_valid, 0);
    chk({tag, "_res_code"}, ifc.res_code, 0);
    chk({tag, "_res_a"}, ifc.res_a, 0);
    chk({tag, "_res_b"}, ifc.res_b, 0);
    chk({tag, "_res_err"}, ifc.res_err, 0);
    chk({tag, "_err_sticky"}, ifc.err_sticky, 0);
  endtask

  initial begin
    tbl[0] = '{a: 3'd6, b: 3'd6, f: 1'b0, code: 3'b010, err: 1'b0};
    tbl[1] = '{a: 3'd2, b: 3'd7, f: 1'b0, code: 3'b100, err: 1'b0};
    tbl[2] = '{a: 3'd7, b: 3'd0, f: 1'b0, code: 3'b001, err: 1'b0};
    tbl[3] = '{a: 3'd0, b: 3'd0, f: 1'b0, code: 3'b010, err: 1'b0};
    tbl[4] = '{a: 3'd0, b: 3'd7, f: 1'b0, code: 3'b100, err: 1'b0};
    tbl[5] = '{a: 3'd3, b: 3'd4, f: 1'b0, code: 3'b100, err: 1'b0};
    tbl[6] = '{a: 3'd4, b: 3'd3, f: 1'b0, code: 3'b001, err: 1'b0};
    tbl[7] = '{a: 3'd1, b: 3'd1, f: 1'b0, code: 3'b010, err: 1'b0};
    tbl[8] = '{a: 3'd6, b: 3'd5, f: 1'b0, code: 3'b001, err: 1'b0};

    ifc.in_valid = 1'b0; ifc.a_bus = '0; ifc.b_bus = '0;
    repeat (2) @(posedge clk); #1;
    chk_reset_outputs("in_reset");
    rst_n = 1'b1;

    // Idle: four bubble frames
    for (int k = 0; k < 4 * W; k++) begin
      @(negedge clk);
      if (k == 0) chk_reset_outputs("first_cycle");
      chk("idle_a_o", ifc.a_o, 0);
      chk("idle_b_o", ifc.b_o, 0);
      chk("idle_in_ready", ifc.in_ready, (k % W) == W - 1);
      chk("idle_res_valid", ifc.res_valid, 0);
    end
    @(posedge clk); #1;

    // Single pair, serial bit order
    send_ref(3'd5, 3'd3);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      chk("ser_a", ifc.a_o, (5 >> k) & 1);
      chk("ser_b", ifc.b_o, (3 >> k) & 1);
    end
    @(posedge clk); #1;
    repeat (2 * W) @(posedge clk); #1;

    // Back-to-back table run; result pulses must be exactly W apart
    have_prev = 0;
    gap_en = 1;
    for (int i = 0; i < 9; i++) send(tbl[i].a, tbl[i].b, tbl[i].f, tbl[i].code, tbl[i].err);
    repeat (2 * W + 3) @(posedge clk); #1;
    gap_en = 0;

    // in_valid held high with a bus that changes every cycle
    ifc.in_valid = 1'b1;
    for (int i = 0; i < 8 * W; i++) begin
      ifc.a_bus = W'($urandom_range(0, (1 << W) - 1));
      ifc.b_bus = W'($urandom_range(0, (1 << W) - 1));
      drv_code = ref_code(ifc.a_bus, ifc.b_bus);
      drv_err = 1'b0;
      @(posedge clk); #1;
    end
    ifc.in_valid = 1'b0;
    repeat (2 * W + 3) @(posedge clk); #1;

    // Forced 000 result from the comparator
    chk("sticky_clear_before", ifc.err_sticky, 0);
    send(3'd4, 3'd1, 1'b1, 3'b000, 1'b1);
    repeat (2 * W + 2) @(posedge clk); #1;
    chk("sticky_after_err", ifc.err_sticky, 1);
    send_ref(3'd2, 3'd2);
    send_ref(3'd5, 3'd1);
    repeat (2 * W + 3) @(posedge clk); #1;
    chk("sticky_holds", ifc.err_sticky, 1);

    // Reset in slot 1 of a DATA frame
    send_ref(3'd6, 3'd2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    res_cnt = 0;
    #1;
    chk_reset_outputs("mid_reset");
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      chk("restart_in_ready", ifc.in_ready, k == W - 1);
    end
    repeat (3 * W) @(posedge clk); #1;
    chk("no_res_after_reset", res_cnt, 0);

    // Random back-to-back pairs
    for (int i = 0; i < 64; i++)
      send_ref(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)));

    for (int i = 0; i < 10 * W && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", sb.size(), 0);
    chk("final_sticky", ifc.err_sticky, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
